// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a saturating fetch counter.
// Optional sticky misaligned-redirect flag, enabled with `define FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          MEM_SIZE = 256
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] imem_instr,
   output logic [31:0] imem_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_pc_plus4,
   output logic [31:0] fetch_count
`ifdef FETCH_MISALIGN_CHK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam logic [31:0] ADDR_MASK = 32'(MEM_SIZE - 1);
   localparam logic [31:0] PC_RST    = RESET_PC & ADDR_MASK;

   logic [31:0] pc_q, pc_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] pc_seq;
   logic        squash;
   logic        load;

   assign pc_seq = (pc_q + 32'd4) & ADDR_MASK;
   // A redirect makes the word fetched this cycle wrong-path, so it squashes like a flush.
   assign squash = flush | redirect_valid;
   assign load   = ~squash & ~stall;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pc_d = pc_seq;
      if (redirect_valid) begin
         pc_d = (redirect_pc & ADDR_MASK) & ~32'd3;
      end else if (stall) begin
         pc_d = pc_q;
      end
   end

   always_comb begin
      ifid_valid_d    = ifid_valid_q;
      ifid_instr_d    = ifid_instr_q;
      ifid_pc_d       = ifid_pc_q;
      ifid_pc_plus4_d = ifid_pc_plus4_q;
      fetch_count_d   = fetch_count_q;
      if (squash) begin
         ifid_valid_d = 1'b0;
         ifid_instr_d = '0;
      end else if (load) begin
         ifid_valid_d    = 1'b1;
         ifid_instr_d    = imem_instr;
         ifid_pc_d       = pc_q;
         ifid_pc_plus4_d = pc_seq;
      end
      if (load && fetch_count_q != 32'hFFFF_FFFF) begin
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pc_q            <= PC_RST;
         ifid_valid_q    <= 1'b0;
         ifid_instr_q    <= '0;
         ifid_pc_q       <= '0;
         ifid_pc_plus4_q <= '0;
         fetch_count_q   <= '0;
      end else begin
         pc_q            <= pc_d;
         ifid_valid_q    <= ifid_valid_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc_q       <= ifid_pc_d;
         ifid_pc_plus4_q <= ifid_pc_plus4_d;
         fetch_count_q   <= fetch_count_d;
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_err_q, misalign_err_d;

   always_comb begin
      misalign_err_d = misalign_err_q;
      if (redirect_valid && redirect_pc[1:0] != 2'b00) begin
         misalign_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         misalign_err_q <= 1'b0;
      end else begin
         misalign_err_q <= misalign_err_d;
      end
   end

   assign misalign_err = misalign_err_q;
`endif

   assign imem_pc       = pc_q;
   assign ifid_valid    = ifid_valid_q;
   assign ifid_instr    = ifid_instr_q;
   assign ifid_pc       = ifid_pc_q;
   assign ifid_pc_plus4 = ifid_pc_plus4_q;
   assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random stall/flush/redirect traffic
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam int MEM_SIZE = 256;
   localparam int WORDS    = MEM_SIZE / 4;

   logic        clk = 1'b0;
   logic        resetN;
   logic        stall, flush, redirect_valid;
   logic [31:0] redirect_pc, imem_instr, imem_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4, fetch_count;
`ifdef FETCH_MISALIGN_CHK_EN
   logic        misalign_err;
`endif

   logic [31:0] mem [WORDS];

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   int unsigned m_pc, m_ifpc, m_ifp4, m_instr, m_cnt;
   bit          m_valid, m_mis;

   fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_SIZE(MEM_SIZE)) dut (
      .clk           (clk),
      .resetN        (resetN),
      .stall         (stall),
      .flush         (flush),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_instr    (imem_instr),
      .imem_pc       (imem_pc),
      .ifid_valid    (ifid_valid),
      .ifid_instr    (ifid_instr),
      .ifid_pc       (ifid_pc),
      .ifid_pc_plus4 (ifid_pc_plus4),
      .fetch_count   (fetch_count)
`ifdef FETCH_MISALIGN_CHK_EN
      ,
      .misalign_err  (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   assign imem_instr = mem[int'(imem_pc / 4) % WORDS];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ifpc = 0; m_ifp4 = 0; m_instr = 0; m_cnt = 0;
      m_valid = 0; m_mis = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".imem_pc"}, imem_pc, m_pc);
      check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
      check({tag, ".instr"}, ifid_instr, m_instr);
      check({tag, ".ifid_pc"}, ifid_pc, m_ifpc);
      check({tag, ".pc_plus4"}, ifid_pc_plus4, m_ifp4);
      check({tag, ".count"}, fetch_count, m_cnt);
`ifdef FETCH_MISALIGN_CHK_EN
      check({tag, ".misalign"}, {31'd0, misalign_err}, {31'd0, m_mis});
`endif
   endtask

   // Apply inputs for one cycle, advance the model across the edge, then compare.
   task automatic step(input string tag, input bit s, input bit f, input bit rv,
                       input logic [31:0] rpc);
      int unsigned fetched;
      stall = s; flush = f; redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk);
      fetched = mem[(m_pc / 4) % WORDS];
      if (f || rv) begin
         m_valid = 0;
         m_instr = 0;
      end else if (!s) begin
         m_valid = 1;
         m_instr = fetched;
         m_ifpc  = m_pc;
         m_ifp4  = (m_pc + 4) % MEM_SIZE;
         if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
      end
      if (rv) begin
         m_pc = ((rpc % MEM_SIZE) / 4) * 4;
         if (rpc % 4 != 0) m_mis = 1;
      end else if (!s) begin
         m_pc = (m_pc + 4) % MEM_SIZE;
      end
      #1;
      check_all(tag);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
      mem[1] = 32'h2011_0001;
      resetN = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      #3 resetN = 1'b1;
      #1;
      check("rel.imem_pc", imem_pc, 32'h0);

      // Sequential start: imem_pc 0 -> 4 -> 8, instruction at 4 lands in IF/ID.
      step("seq0", 0, 0, 0, 0);
      check("seq0.pc4", imem_pc, 32'h4);
      step("seq1", 0, 0, 0, 0);
      check("seq1.pc8", imem_pc, 32'h8);
      check("seq1.ifid_pc", ifid_pc, 32'h4);
      check("seq1.instr", ifid_instr, 32'h2011_0001);

      // Stall for three cycles at PC 8, then resume.
      for (int i = 0; i < 3; i++) begin
         step("stall", 1, 0, 0, 0);
         check("stall.pc", imem_pc, 32'h8);
         check("stall.cnt", fetch_count, 32'd2);
         check("stall.ifid_pc", ifid_pc, 32'h4);
      end
      step("resume", 0, 0, 0, 0);
      check("resume.pc", imem_pc, 32'd12);
      check("resume.ifid_pc", ifid_pc, 32'h8);

      // Redirect wins over stall and squashes the wrong-path fetch.
      step("redir", 1, 0, 1, 32'h40);
      check("redir.pc", imem_pc, 32'h40);
      check("redir.valid", {31'd0, ifid_valid}, 32'd0);
      step("redir1", 0, 0, 0, 0);
      check("redir1.ifid_pc", ifid_pc, 32'h40);

      // Flush together with stall: IF/ID squashed, PC holds.
      step("flst", 1, 1, 0, 0);
      check("flst.pc", imem_pc, 32'h44);

      // Wrap from the top of memory.
      step("to252", 0, 0, 1, 32'd252);
      step("wrap", 0, 0, 0, 0);
      check("wrap.pc", imem_pc, 32'h0);
      check("wrap.ifid_pc", ifid_pc, 32'd252);
      check("wrap.pc_plus4", ifid_pc_plus4, 32'h0);

      // Out-of-range target bits are masked to the memory size.
      step("mask", 0, 0, 1, 32'hFFFF_FF13);
      check("mask.pc", imem_pc, 32'h10);

`ifdef FETCH_MISALIGN_CHK_EN
      step("mis", 0, 0, 1, 32'h22);
      check("mis.pc", imem_pc, 32'h20);
      check("mis.flag", {31'd0, misalign_err}, 32'd1);
      step("mis_hold", 0, 0, 1, 32'h80);
      check("mis_hold.flag", {31'd0, misalign_err}, 32'd1);
`endif

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         bit s, f, rv;
         s  = ($urandom_range(3) == 0);
         f  = ($urandom_range(9) == 0);
         rv = ($urandom_range(9) == 0);
         step("rnd", s, f, rv, $urandom);
      end

      // Asynchronous reset mid-stream after five fresh loads.
      resetN = 1'b0;
      #2 resetN = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) step("pre", 0, 0, 0, 0);
      check("pre.cnt", fetch_count, 32'd5);
      #2 resetN = 1'b0;
      stall = 1; redirect_valid = 1; redirect_pc = 32'h80;
      #1;
      model_reset();
      check_all("async");
      @(posedge clk);
      #1;
      check_all("async_hold");
      #2 resetN = 1'b1;
      step("post", 0, 0, 0, 0);
      check("post.ifid_pc", ifid_pc, 32'h0);
      check("post.cnt", fetch_count, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and resetN.
REQ-002 The block SHALL have parameters:
- RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- MEM_SIZE, default 256: instruction memory depth in byte addresses; power of two, at least 8.
REQ-003 The block SHALL have these ports, in this order:
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous active-low reset
- stall  in  1  hold PC and IF/ID register
- flush  in  1  squash IF/ID contents
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  branch/jump target
- imem_instr  in  32  instruction returned combinationally for imem_pc
- imem_pc  out  32  fetch address to instruction memory
- ifid_valid  out  1  IF/ID slot holds a real instruction
- ifid_instr  out  32  registered instruction
- ifid_pc  out  32  PC of ifid_instr
- ifid_pc_plus4  out  32  ifid_pc+4 (mod MEM_SIZE)
- fetch_count  out  32  count of instructions accepted into IF/ID
- misalign_err  out  1  sticky misaligned-target flag; exists only with the macro in REQ-017

Function
REQ-004 The block SHALL drive imem_pc combinationally from the internal PC register, with zero cycles of latency.
REQ-005 PC update on a rising edge, first matching case wins:
- redirect_valid=1: PC <= redirect_pc & (MEM_SIZE-1), with bits [1:0] forced to 0.
- stall=1: PC holds.
- otherwise: PC <= (PC+4) mod MEM_SIZE.
REQ-006 Redirect SHALL take priority over stall for the PC update.
REQ-007 Sequential fetch SHALL wrap: PC=MEM_SIZE-4 is followed by PC=0 when there is no redirect and no stall.
REQ-008 IF/ID update on a rising edge, first matching case wins:
- flush=1 or redirect_valid=1: ifid_valid<=0, ifid_instr<=0 (NOP), ifid_pc and ifid_pc_plus4 hold.
- stall=1: all IF/ID outputs hold.
- otherwise: ifid_valid<=1, ifid_instr<=imem_instr, ifid_pc<=PC, ifid_pc_plus4<=(PC+4) mod MEM_SIZE.
REQ-009 The instruction fetched in the same cycle as redirect_valid is wrong-path and SHALL never reach IF/ID as valid.
REQ-010 flush with stall SHALL squash IF/ID while the PC still obeys REQ-005.
REQ-011 fetch_count SHALL increment by 1 on each edge that takes the load case of REQ-008.
REQ-012 fetch_count SHALL saturate at 32'hFFFF_FFFF and not wrap.
REQ-013 The block SHALL have exactly two sequential elements plus the counter: the PC register and the IF/ID register.
REQ-014 There SHALL be no combinational path from stall, flush or redirect_* to any output other than through registers.

Reset
REQ-015 When resetN=0, the block SHALL asynchronously set:
- PC = RESET_PC & (MEM_SIZE-1), so imem_pc shows this value.
- ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus4=0.
- fetch_count=0, misalign_err=0.
REQ-016 Reset asserted mid-operation, including during a stall or redirect, SHALL override all other inputs immediately; the first fetch after deassertion SHALL come from the reset PC.

Configuration
REQ-017 With FETCH_MISALIGN_CHK_EN defined:
- misalign_err port SHALL exist.
- misalign_err SHALL set on any edge where redirect_valid=1 and redirect_pc[1:0]!=0.
- misalign_err SHALL stay set until reset.
- the PC update still follows REQ-005.
REQ-018 Without FETCH_MISALIGN_CHK_EN, the misalign_err port and its logic SHALL be absent, and low target bits SHALL be dropped silently.

Verification
REQ-019 Reset release with RESET_PC=0, imem returning 32'h2011_0001 at PC 4 -> imem_pc reads 0,4,8 on successive cycles; ifid_pc=4 and ifid_instr=32'h2011_0001 one cycle after imem_pc=4.
REQ-020 stall held 3 cycles at PC=8 -> imem_pc stays 8 and IF/ID outputs are unchanged; fetch_count does not advance; fetch resumes at 12.
REQ-021 redirect_valid=1, redirect_pc=0x40, with stall=1 in the same cycle -> next imem_pc=0x40 and ifid_valid=0; the next cycle loads ifid_pc=0x40.
REQ-022 MEM_SIZE=256, PC=252, no stall -> next imem_pc=0 and ifid_pc_plus4=0 for the instruction at 252.
REQ-023 resetN pulsed low mid-stream at fetch_count=5 -> all outputs reset without waiting for clk; after release fetch restarts at RESET_PC and fetch_count counts from 0.
REQ-024 With FETCH_MISALIGN_CHK_EN defined, redirect_pc=0x22 -> imem_pc=0x20 and misalign_err=1, which holds through later aligned redirects until reset.
